seg_scan_driver: RTL
====================

// Module: seg_scan_driver
// PURPOSE
//  Multiplexed 7-segment scan driver downstream of the front-panel interface block.
//  - Consumes the 40-bit display word (5 digits x 8 segments) and the display mode.
//  - Time-multiplexes the digits with an anti-ghost blanking gap.
//  - Applies flash or blank per mode, and latches new content only at frame boundaries (no tearing).
// PARAMETERS
//  DIGITS        5     number of digits; byte i of disp_data drives digit i (byte 0 = [7:0] = rightmost)
//  SCAN_DIV      4000  clk cycles per digit slot (20 MHz -> 5 kHz slot, 1 kHz frame)
//  BLANK_CYC     200   cycles at slot start with all outputs off; must be < SCAN_DIV
//  FLASH_FRAMES  500   frames per flash half-period (0.5 s on / 0.5 s off at defaults)
//  FLASH_LIMIT   5     on/off flash cycles before auto-stop (SEG_FLASH_COUNT_EN only)
// PORTS
//  clk          in   1         system clock
//  reset        in   1         asynchronous, active-low reset
//  disp_data    in   8*DIGITS  segment bytes, bit7 = dp, bits6:0 = g..a, active-high
//  disp_mode    in   3         3'd0 constant, 3'd1 flash, 3'd2 blank; other codes = constant
//  seg_sel      out  DIGITS    one-hot digit enable, active-high
//  seg_out      out  8         segment drive for the selected digit, active-high
//  frame_start  out  1         1-cycle pulse on the frame latch cycle
//  flash_done   out  1         1-cycle pulse when flash auto-stop fires; constant 0 without macro
// BEHAVIOUR
//  - Reset (async): seg_sel=0, seg_out=0, frame_start=0, flash_done=0.
//  - Reset clears all counters to 0, digit=0, shadow data=0, shadow mode=constant, flash phase=ON.
//  - Counters: slot_cnt runs 0..SCAN_DIV-1. At the wrap, digit advances 0..DIGITS-1, then wraps to 0.
//  - Frame latch: the cycle with digit==0 and slot_cnt==0 loads shadow_data<=disp_data and
//    shadow_mode<=disp_mode, and frame_start=1 on that cycle.
//    - The first clk edge after reset release is a latch cycle.
//    - Input changes at any other time are invisible until the next latch.
//  - Slot FSM, two states:
//    - BLANK (slot_cnt < BLANK_CYC): seg_sel=0, seg_out=0.
//    - DRIVE (remaining cycles): seg_sel=1<<digit, seg_out=shadow byte[digit].
//  - Outputs are registered. seg_sel and seg_out change on the same edge, one cycle after the counter
//    state that selects them.
//  - Blank mode: DRIVE forces seg_sel=0 and seg_out=0. Counters and frame_start keep running.
//  - Flash mode:
//    - flash_cnt counts frames and toggles phase every FLASH_FRAMES frames.
//    - OFF phase: DRIVE outputs 0, as in blank mode.
//    - When shadow_mode enters flash from any other mode, flash_cnt=0 and phase=ON, so the display
//      starts visible.
//    - In non-flash modes, phase is held ON and flash_cnt is held at 0.
//  - Frame length = DIGITS*SCAN_DIV cycles. Ever-mode/data changes never shorten or restart a slot.
//  - Reset mid-DRIVE: outputs drop to 0 immediately and the scan restarts at digit 0.
// CONFIGURATION
//  - SEG_FLASH_COUNT_EN defined:
//    - Count completed OFF->ON phase transitions while in flash mode.
//    - On reaching FLASH_LIMIT: flash_done pulses 1 cycle, and the display is forced constant
//      (phase held ON) until shadow_mode leaves flash.
//    - Re-entering flash restarts the count.
//    - This supports the panel's startup message, which flashes N times.
//  - SEG_FLASH_COUNT_EN undefined: flash runs indefinitely, flash_done is tied 0, FLASH_LIMIT is unused.
// TESTING (bench params DIGITS=5 SCAN_DIV=8 BLANK_CYC=2 FLASH_FRAMES=2 FLASH_LIMIT=3)
//  1. Release reset with disp_data=40'h3F_06_5B_4F_66 and mode=0:
//     - frame_start pulses at cycle 0, then every 40 cycles.
//     - Per 8-cycle slot: 2 cycles seg_sel=0, then 6 cycles of seg_sel=00001/seg_out=66.
//     - Following slots: 00010/4F, 00100/5B, 01000/06, 10000/3F.
//  2. Change disp_data to all-8'hFF at cycle 13:
//     - Outputs keep the old bytes through cycle 39.
//     - From cycle 40 (latch) on, FF is shown.
//  3. Switch mode=1:
//     - From the next latch: 2 frames visible, 2 frames with seg_sel=0/seg_out=0, repeating.
//     - The first flash frame is visible.
//  4. mode=2: seg_sel and seg_out stay 0 for whole frames, and frame_start still pulses every 40 cycles.
//  5. Assert reset mid-DRIVE of digit 3: outputs are 0 in the same cycle (async). After release,
//     the scan restarts at digit 0 with the shadow reloaded.
//  6. With SEG_FLASH_COUNT_EN and mode=1 held:
//     - After the 3rd OFF->ON transition, flash_done pulses once and the display stays constant.
//     - mode 0 then 1 restarts flashing.

Source files
------------

// File: rtl/seg_scan_if.sv
// seg_scan_if
//   Bundle between the front-panel interface block (master) and the
//   multiplexed 7-segment scan driver (slave).
// Signals
//   disp_data    8*DIGITS  segment bytes, byte i = digit i, bit7 = dp, bits6:0 = g..a
//   disp_mode    3         3'd0 constant, 3'd1 flash, 3'd2 blank, others constant
//   seg_sel      DIGITS    one-hot digit enable, active-high
//   seg_out      8         segment drive for the selected digit, active-high
//   frame_start  1         1-cycle pulse on the frame latch cycle
//   flash_done   1         1-cycle pulse when flash auto-stop fires
interface seg_scan_if #(
    parameter int unsigned DIGITS = 5
);
    logic [8*DIGITS-1:0] disp_data;
    logic [2:0]          disp_mode;
    logic [DIGITS-1:0]   seg_sel;
    logic [7:0]          seg_out;
    logic                frame_start;
    logic                flash_done;

    modport master (
        output disp_data, disp_mode,
        input  seg_sel, seg_out, frame_start, flash_done
    );

    modport slave (
        input  disp_data, disp_mode,
        output seg_sel, seg_out, frame_start, flash_done
    );
endinterface

// File: rtl/seg_scan_driver.sv
// seg_scan_driver
//   Multiplexed 7-segment scan driver. Time-multiplexes DIGITS digits, each
//   slot starting with an all-off anti-ghost gap, and applies constant / flash /
//   blank display modes. Display data and mode are latched only at the frame
//   boundary (digit 0, slot count 0), so a frame never tears.
// Ports
//   clk     in   system clock
//   reset   in   asynchronous, active-low reset
//   bus     seg_scan_if.slave: disp_data/disp_mode in; seg_sel, seg_out,
//           frame_start, flash_done out (all outputs registered)
// Configuration
//   SEG_FLASH_COUNT_EN  when defined, flash mode stops after FLASH_LIMIT
//                       OFF->ON transitions, pulses flash_done and holds the
//                       display on until the mode leaves flash. When undefined,
//                       flash runs forever and flash_done is tied 0.
module seg_scan_driver #(
    parameter int unsigned DIGITS       = 5,
    parameter int unsigned SCAN_DIV     = 4000,
    parameter int unsigned BLANK_CYC    = 200,
    parameter int unsigned FLASH_FRAMES = 500,
    parameter int unsigned FLASH_LIMIT  = 5
) (
    input  logic      clk,
    input  logic      reset,
    seg_scan_if.slave bus
);

    localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned FW = $clog2(FLASH_FRAMES + 1);

    localparam logic [SW-1:0] SLOT_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] BLANK_END  = SW'(BLANK_CYC);
    localparam logic [DW-1:0] DIGIT_LAST = DW'(DIGITS - 1);
    localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_FRAMES - 1);

    if (BLANK_CYC >= SCAN_DIV || FLASH_FRAMES == 0 || FLASH_LIMIT == 0 || DIGITS == 0)
    begin : g_bad_params
        $error("seg_scan_driver: invalid parameter set");
    end

    typedef enum logic {
        SLOT_BLANK,
        SLOT_DRIVE
    } slot_state_t;

    typedef enum logic [2:0] {
        MODE_CONST = 3'd0,
        MODE_FLASH = 3'd1,
        MODE_BLANK = 3'd2
    } mode_t;

    // A slot with no blanking gap starts straight in DRIVE.
    localparam slot_state_t STATE_RST = (BLANK_CYC > 0) ? SLOT_BLANK : SLOT_DRIVE;

    slot_state_t         state, state_next;
    logic [SW-1:0]       slot_cnt, slot_next;
    logic [DW-1:0]       digit, digit_next;
    logic [8*DIGITS-1:0] shadow_data, shadow_data_next;
    logic [2:0]          shadow_mode, shadow_mode_next;
    logic [FW-1:0]       flash_cnt, flash_cnt_next;
    logic                phase_on, phase_on_next;
    logic                flash_hold;
    logic                latch;
    logic [DIGITS-1:0]   seg_sel_next;
    logic [7:0]          seg_out_next;
    logic                frame_start_next;
    logic                flash_done_next;

`ifdef SEG_FLASH_COUNT_EN
    localparam int unsigned LW = $clog2(FLASH_LIMIT + 1);
    localparam logic [LW-1:0] LIMIT_LAST = LW'(FLASH_LIMIT - 1);

    logic [LW-1:0] on_cnt, on_cnt_next;
    logic          flash_hold_next;
`else
    assign flash_hold = 1'b0;
`endif

    always_comb begin
        state_next       = state;
        slot_next        = (slot_cnt == SLOT_LAST) ? '0 : slot_cnt + 1'b1;
        digit_next       = digit;
        shadow_data_next = shadow_data;
        shadow_mode_next = shadow_mode;
        flash_cnt_next   = flash_cnt;
        phase_on_next    = phase_on;
        frame_start_next = 1'b0;
        flash_done_next  = 1'b0;
        seg_sel_next     = '0;
        seg_out_next     = '0;
`ifdef SEG_FLASH_COUNT_EN
        on_cnt_next      = on_cnt;
        flash_hold_next  = flash_hold;
`endif

        latch = (digit == '0) && (slot_cnt == '0);

        if (slot_cnt == SLOT_LAST) begin
            digit_next = (digit == DIGIT_LAST) ? '0 : digit + 1'b1;
        end

        // state always mirrors slot_cnt: BLANK while slot_cnt < BLANK_CYC
        unique case (state)
            SLOT_BLANK: if (slot_next >= BLANK_END) state_next = SLOT_DRIVE;
            SLOT_DRIVE: if (slot_next < BLANK_END)  state_next = SLOT_BLANK;
        endcase

        if (latch) begin
            frame_start_next = 1'b1;
            shadow_data_next = bus.disp_data;
            shadow_mode_next = bus.disp_mode;
            if (bus.disp_mode != MODE_FLASH || shadow_mode != MODE_FLASH) begin
                // Not flashing, or a fresh flash stint: start visible, counts cleared.
                flash_cnt_next = '0;
                phase_on_next  = 1'b1;
`ifdef SEG_FLASH_COUNT_EN
                on_cnt_next     = '0;
                flash_hold_next = 1'b0;
`endif
            end else if (!flash_hold) begin
                if (flash_cnt == FLASH_LAST) begin
                    flash_cnt_next = '0;
                    phase_on_next  = !phase_on;
`ifdef SEG_FLASH_COUNT_EN
                    if (!phase_on) begin
                        on_cnt_next = on_cnt + 1'b1;
                        if (on_cnt == LIMIT_LAST) begin
                            flash_hold_next = 1'b1;
                            flash_done_next = 1'b1;
                        end
                    end
`endif
                end else begin
                    flash_cnt_next = flash_cnt + 1'b1;
                end
            end
        end

        // Outputs reflect the current counter position with the content that
        // is valid after this edge, so a latch cycle already drives new data.
        if (state == SLOT_DRIVE && shadow_mode_next != MODE_BLANK && phase_on_next) begin
            seg_sel_next = DIGITS'(1) << digit;
            seg_out_next = shadow_data_next[{digit, 3'b000} +: 8];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= STATE_RST;
            slot_cnt        <= '0;
            digit           <= '0;
            shadow_data     <= '0;
            shadow_mode     <= MODE_CONST;
            flash_cnt       <= '0;
            phase_on        <= 1'b1;
            bus.seg_sel     <= '0;
            bus.seg_out     <= '0;
            bus.frame_start <= 1'b0;
            bus.flash_done  <= 1'b0;
`ifdef SEG_FLASH_COUNT_EN
            on_cnt          <= '0;
            flash_hold      <= 1'b0;
`endif
        end else begin
            state           <= state_next;
            slot_cnt        <= slot_next;
            digit           <= digit_next;
            shadow_data     <= shadow_data_next;
            shadow_mode     <= shadow_mode_next;
            flash_cnt       <= flash_cnt_next;
            phase_on        <= phase_on_next;
            bus.seg_sel     <= seg_sel_next;
            bus.seg_out     <= seg_out_next;
            bus.frame_start <= frame_start_next;
            bus.flash_done  <= flash_done_next;
`ifdef SEG_FLASH_COUNT_EN
            on_cnt          <= on_cnt_next;
            flash_hold      <= flash_hold_next;
`endif
        end
    end

endmodule
